// File: rtl/lcd_responder_if.sv
// lcd_responder_if
//   Panel-side 4-bit character-LCD bus (HD44780 style).
//   master : the LCD controller (drives the pins)
//   slave  : the panel / responder (observes the pins)
//   SF_D   [11:8] data nibble
//   LCD_E         enable strobe
//   LCD_RS        0 = command, 1 = data
//   LCD_RW        0 = write, 1 = read
interface lcd_responder_if;
  logic [11:8] SF_D;
  logic        LCD_E;
  logic        LCD_RS;
  logic        LCD_RW;

  modport master (output SF_D, output LCD_E, output LCD_RS, output LCD_RW);
  modport slave  (input  SF_D, input  LCD_E, input  LCD_RS, input  LCD_RW);
endinterface

// File: rtl/lcd_responder.sv
// lcd_responder
//   HD44780-compatible responder for the 4-bit character-LCD bus. Tracks the
//   power-on init handshake, reassembles nibble pairs, executes commands,
//   keeps a 32-character display image and flags protocol-timing violations.
//
//   Ports
//     clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//     bus         : LCD pins (SF_D, LCD_E, LCD_RS, LCD_RW), slave side
//     rd_addr     : image read index (0-15 line 1, 16-31 line 2)
//     rd_data     : image byte at rd_addr, registered (one cycle later)
//     busy        : execution timer running
//     error       : sticky protocol-violation flag
//     mode_4bit   : 4-bit interface established
//     display_on  : display-control D bit
//     cursor      : current DDRAM address
//     wr_strobe   : one-cycle pulse per stored character
//     wr_char     : character written, valid with wr_strobe
//
//   Pin-level LCD_E falling edge -> effect visible 3 clk later
//   (2 synchronizer flops + 1 execute register).
module lcd_responder #(
  parameter int unsigned BUSY_CMD   = 2000,
  parameter int unsigned BUSY_CLEAR = 82000,
  parameter int unsigned MIN_E_HIGH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_responder_if.slave        bus,
  input  logic [4:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  busy,
  output logic                  error,
  output logic                  mode_4bit,
  output logic                  display_on,
  output logic [6:0]            cursor,
  output logic                  wr_strobe,
  output logic [7:0]            wr_char
);

  typedef enum logic [1:0] {
    S_8BIT    = 2'd0,
    S_4BIT_HI = 2'd1,
    S_4BIT_LO = 2'd2
  } state_t;

  localparam int unsigned BUSY_MAX = (BUSY_CLEAR > BUSY_CMD) ? BUSY_CLEAR : BUSY_CMD;
  localparam int TMR_W = $clog2(BUSY_MAX + 1);
  localparam int CNT_W = $clog2(MIN_E_HIGH + 1);
  localparam logic [TMR_W-1:0] LD_CMD   = TMR_W'(BUSY_CMD);
  localparam logic [TMR_W-1:0] LD_CLEAR = TMR_W'(BUSY_CLEAR);
  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_E_HIGH);
  localparam logic [7:0]       BLANK    = 8'h20;

  // Returns {hit, index}. Line 2 starts at DDRAM 0x28; its low nibble runs
  // 8..F,0..7 so subtracting 8 (mod 16) yields the 0..15 column.
  function automatic logic [5:0] map_addr(input logic [6:0] c);
    if (c <= 7'h0F)
      map_addr = {1'b1, 1'b0, c[3:0]};
    else if (c >= 7'h28 && c <= 7'h37)
      map_addr = {1'b1, 1'b1, c[3:0] - 4'h8};
    else
      map_addr = 6'd0;
  endfunction

  function automatic logic [6:0] step_cursor(input logic [6:0] c, input logic inc);
    step_cursor = inc ? c + 7'd1 : c - 7'd1;
  endfunction

  // ---- stage p0/p1: two-flop input synchronizer ----
  logic [3:0] d_p0, d_p1;
  logic       rs_p0, rs_p1, rw_p0, rw_p1;
  logic       e_p0, e_p1;

  always_ff @(posedge clk) begin
    d_p0  <= bus.SF_D;
    d_p1  <= d_p0;
    rs_p0 <= bus.LCD_RS;
    rs_p1 <= rs_p0;
    rw_p0 <= bus.LCD_RW;
    rw_p1 <= rw_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_p0 <= 1'b0;
      e_p1 <= 1'b0;
    end else begin
      e_p0 <= bus.LCD_E;
      e_p1 <= e_p0;
    end
  end

  // ---- stage p2: edge detect, high-width count, pulse qualification ----
  logic             e_p2;
  logic [CNT_W-1:0] e_cnt;
  logic             vld_p2;
  logic             short_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_p2  <= 1'b0;
      e_cnt <= '0;
    end else begin
      e_p2 <= e_p1;
      if (e_p1) begin
        if (e_cnt != '1) e_cnt <= e_cnt + CNT_W'(1);
      end else begin
        e_cnt <= '0;
      end
    end
  end

  // Falling edge of synced E; read cycles are dropped before any checking.
  assign vld_p2   = e_p2 & ~e_p1 & ~rw_p1;
  assign short_p2 = (e_cnt < MIN_W);

  // ---- stage p3: execute ----
  state_t           state, state_nxt;
  logic [3:0]       hi_nib, hi_nxt;
  logic [6:0]       cur_nxt;
  logic             id_inc, id_nxt;
  logic             disp_nxt, mode_nxt, err_nxt;
  logic [TMR_W-1:0] timer, tmr_val;
  logic             tmr_ld;
  logic             fill_go, fill_act;
  logic [4:0]       fill_idx;
  logic             img_we;
  logic [4:0]       img_idx;
  logic             strobe_nxt;
  logic [7:0]       cmd_byte;
  logic [5:0]       map_res;
  logic [7:0]       image [32];

  assign cmd_byte = {hi_nib, d_p1};
  assign map_res  = map_addr(cursor);
  assign busy     = (timer != '0);

  always_comb begin
    state_nxt  = state;
    hi_nxt     = hi_nib;
    cur_nxt    = cursor;
    id_nxt     = id_inc;
    disp_nxt   = display_on;
    mode_nxt   = mode_4bit;
    err_nxt    = error;
    tmr_ld     = 1'b0;
    tmr_val    = LD_CMD;
    fill_go    = 1'b0;
    img_we     = 1'b0;
    img_idx    = map_res[4:0];
    strobe_nxt = 1'b0;

    if (vld_p2) begin
      if (short_p2 || busy) begin
        err_nxt = 1'b1;
      end else begin
        case (state)
          S_8BIT: begin
            if (d_p1 == 4'h3) begin
              tmr_ld = 1'b1;
            end else if (d_p1 == 4'h2) begin
              state_nxt = S_4BIT_HI;
              mode_nxt  = 1'b1;
              tmr_ld    = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end

          S_4BIT_HI: begin
            hi_nxt    = d_p1;
            state_nxt = S_4BIT_LO;
          end

          S_4BIT_LO: begin
            state_nxt = S_4BIT_HI;
            if (rs_p1) begin
              img_we     = map_res[5];
              strobe_nxt = map_res[5];
              cur_nxt    = step_cursor(cursor, id_inc);
              tmr_ld     = 1'b1;
            end else if (cmd_byte[7]) begin
              cur_nxt = cmd_byte[6:0];
              tmr_ld  = 1'b1;
            end else if (cmd_byte[6]) begin
              tmr_ld = 1'b1;
            end else if (cmd_byte[5]) begin
              if (cmd_byte[4]) begin
                state_nxt = S_8BIT;
                mode_nxt  = 1'b0;
              end
              tmr_ld = 1'b1;
            end else if (cmd_byte[4]) begin
              tmr_ld = 1'b1;
            end else if (cmd_byte[3]) begin
              disp_nxt = cmd_byte[2];
              tmr_ld   = 1'b1;
            end else if (cmd_byte[2]) begin
              id_nxt = cmd_byte[1];
              tmr_ld = 1'b1;
            end else if (cmd_byte[1]) begin
              cur_nxt = 7'd0;
              tmr_ld  = 1'b1;
              tmr_val = LD_CLEAR;
            end else if (cmd_byte[0]) begin
              fill_go = 1'b1;
              cur_nxt = 7'd0;
              id_nxt  = 1'b1;
              tmr_ld  = 1'b1;
              tmr_val = LD_CLEAR;
            end
          end

          default: state_nxt = S_8BIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_8BIT;
      hi_nib     <= 4'h0;
      cursor     <= 7'd0;
      id_inc     <= 1'b1;
      display_on <= 1'b0;
      mode_4bit  <= 1'b0;
      error      <= 1'b0;
      timer      <= '0;
      wr_strobe  <= 1'b0;
      wr_char    <= 8'h00;
    end else begin
      state      <= state_nxt;
      hi_nib     <= hi_nxt;
      cursor     <= cur_nxt;
      id_inc     <= id_nxt;
      display_on <= disp_nxt;
      mode_4bit  <= mode_nxt;
      error      <= err_nxt;
      wr_strobe  <= strobe_nxt;
      if (strobe_nxt) wr_char <= cmd_byte;
      if (tmr_ld)
        timer <= tmr_val;
      else if (timer != '0)
        timer <= timer - TMR_W'(1);
    end
  end

  // Clear writes one blank per cycle; the clear busy time covers all 32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_act <= 1'b0;
      fill_idx <= 5'd0;
    end else if (fill_go) begin
      fill_act <= 1'b1;
      fill_idx <= 5'd0;
    end else if (fill_act) begin
      fill_idx <= fill_idx + 5'd1;
      if (fill_idx == 5'd31) fill_act <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) image[i] <= BLANK;
      rd_data <= BLANK;
    end else begin
      if (fill_act)
        image[fill_idx] <= BLANK;
      else if (img_we)
        image[img_idx] <= cmd_byte;
      rd_data <= image[rd_addr];
    end
  end

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder
//   Directed bench for lcd_responder. A transaction-level model predicts
//   flags, cursor, busy window, strobes and the display image for every
//   pulse sent; a compare process checks the DUT against it each cycle.
module tb_lcd_responder;
  localparam int BUSY_CMD   = 300;
  localparam int BUSY_CLEAR = 1200;
  localparam int MIN_E      = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data, wr_char;
  logic       busy, error, mode_4bit, display_on, wr_strobe;
  logic [6:0] cursor;

  lcd_responder_if bus();

  lcd_responder #(.BUSY_CMD(BUSY_CMD), .BUSY_CLEAR(BUSY_CLEAR), .MIN_E_HIGH(MIN_E)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .error(error), .mode_4bit(mode_4bit), .display_on(display_on),
    .cursor(cursor), .wr_strobe(wr_strobe), .wr_char(wr_char));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  // model state
  logic [7:0] m_img [32];
  logic [6:0] m_cur;
  logic [3:0] m_hi;
  bit         m_id, m_disp, m_4b, m_err, m_half;
  int         m_busy_end, m_strobe_cyc;
  logic [7:0] m_char;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_img[i] = 8'h20;
    m_cur = 7'd0; m_hi = 4'h0; m_id = 1'b1; m_disp = 1'b0; m_4b = 1'b0;
    m_err = 1'b0; m_half = 1'b0; m_busy_end = 0; m_strobe_cyc = -1; m_char = 8'h00;
  endtask

  // Pulse falling after edge kf: accepted iff wide enough and the
  // execution window has ended by edge kf+2; effects land at edge kf+3.
  task automatic model_pulse(input bit rs, input bit rw, input logic [3:0] d, input int w, input int kf);
    logic [7:0] b;
    int idx;
    if (rw) return;
    if (w < MIN_E || kf + 2 < m_busy_end) begin m_err = 1'b1; return; end
    if (!m_4b) begin
      if (d == 4'h3) m_busy_end = kf + 3 + BUSY_CMD;
      else if (d == 4'h2) begin m_4b = 1'b1; m_half = 1'b0; m_busy_end = kf + 3 + BUSY_CMD; end
      else m_err = 1'b1;
    end else if (!m_half) begin
      m_hi = d; m_half = 1'b1;
    end else begin
      m_half = 1'b0;
      b = {m_hi, d};
      if (rs) begin
        idx = -1;
        if (int'(m_cur) <= 'h0F) idx = int'(m_cur);
        else if (int'(m_cur) >= 'h28 && int'(m_cur) <= 'h37) idx = int'(m_cur) - 'h28 + 16;
        if (idx >= 0) begin m_img[idx] = b; m_strobe_cyc = kf + 3; m_char = b; end
        m_cur = m_id ? 7'(m_cur + 7'd1) : 7'(m_cur - 7'd1);
        m_busy_end = kf + 3 + BUSY_CMD;
      end else if (b >= 8'h80) begin m_cur = b[6:0]; m_busy_end = kf + 3 + BUSY_CMD; end
      else if (b >= 8'h40) m_busy_end = kf + 3 + BUSY_CMD;
      else if (b >= 8'h20) begin
        if (b[4]) begin m_4b = 1'b0; m_half = 1'b0; end
        m_busy_end = kf + 3 + BUSY_CMD;
      end
      else if (b >= 8'h10) m_busy_end = kf + 3 + BUSY_CMD;
      else if (b >= 8'h08) begin m_disp = b[2]; m_busy_end = kf + 3 + BUSY_CMD; end
      else if (b >= 8'h04) begin m_id = b[1]; m_busy_end = kf + 3 + BUSY_CMD; end
      else if (b >= 8'h02) begin m_cur = 7'd0; m_busy_end = kf + 3 + BUSY_CLEAR; end
      else if (b == 8'h01) begin
        for (int i = 0; i < 32; i++) m_img[i] = 8'h20;
        m_cur = 7'd0; m_id = 1'b1; m_busy_end = kf + 3 + BUSY_CLEAR;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("status{busy,error,mode,disp,cursor,strobe}",
            32'({busy, error, mode_4bit, display_on, cursor, wr_strobe}),
            32'({(cyc < m_busy_end), m_err, m_4b, m_disp, m_cur, (cyc == m_strobe_cyc)}));
      if (cyc == m_strobe_cyc) check("wr_char", 32'(wr_char), 32'(m_char));
    end
  end

  // Returns #1 after the posedge that makes cyc == n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_at(input bit rs, input bit rw, input logic [3:0] d, input int w, input int kf);
    wait_cyc(kf - w - 1);
    bus.SF_D = d; bus.LCD_RS = rs; bus.LCD_RW = rw;
    wait_cyc(kf - w);
    bus.LCD_E = 1'b1;
    wait_cyc(kf);
    bus.LCD_E = 1'b0;
    wait_cyc(kf + 3);
    model_pulse(rs, rw, d, w, kf);
  endtask

  task automatic send(input bit rs, input logic [3:0] d, input int w);
    pulse_at(rs, 1'b0, d, w, cyc + w + 1);
  endtask

  task automatic wait_idle();
    wait_cyc(m_busy_end + 2);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send(rs, b[7:4], 13);
    send(rs, b[3:0], 13);
  endtask

  task automatic read_chk(input int a, input logic [7:0] exp);
    rd_addr = 5'(a);
    @(posedge clk); @(negedge clk);
    check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic sweep_model();
    for (int i = 0; i < 32; i++) read_chk(i, m_img[i]);
  endtask

  task automatic do_reset();
    wait_cyc(cyc + 1);
    rst_n = 1'b0;
    model_reset();
    wait_cyc(cyc + 3);
    rst_n = 1'b1;
    wait_cyc(cyc + 3);
  endtask

  task automatic init_4bit();
    send(1'b0, 4'h3, 13); wait_idle();
    send(1'b0, 4'h3, 13); wait_idle();
    send(1'b0, 4'h3, 13); wait_idle();
    send(1'b0, 4'h2, 13); wait_idle();
  endtask

  initial begin
    int t0;
    bus.SF_D = 4'h0; bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0;
    model_reset();
    wait_cyc(2);
    chk_en = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(8);

    // 1: reset state
    check("reset flags", 32'({busy, error, mode_4bit, display_on, cursor, wr_strobe, wr_char}), 32'h0);
    for (int i = 0; i < 32; i++) read_chk(i, 8'h20);

    // 2: init handshake
    init_4bit();
    check("mode_4bit after init", 32'(mode_4bit), 32'h1);
    check("error after init", 32'(error), 32'h0);

    // 3: configure and clear
    send_byte(1'b0, 8'h28); wait_idle();
    send_byte(1'b0, 8'h06); wait_idle();
    send_byte(1'b0, 8'h0C); wait_idle();
    check("display_on", 32'(display_on), 32'h1);
    send_byte(1'b0, 8'h01);
    t0 = cyc;
    wait_cyc(t0 + BUSY_CLEAR - 1);
    check("busy last clear cycle", 32'(busy), 32'h1);
    wait_cyc(t0 + BUSY_CLEAR);
    check("busy after clear", 32'(busy), 32'h0);
    check("cursor after clear", 32'(cursor), 32'h0);
    sweep_model();

    // 4: character writes; first nibble lands exactly as busy drops
    send_byte(1'b0, 8'h80);
    pulse_at(1'b1, 1'b0, 4'h4, 13, m_busy_end - 2);
    send(1'b1, 4'h1, 13);
    check("wr_strobe A", 32'(wr_strobe), 32'h1);
    check("wr_char A", 32'(wr_char), 32'h41);
    check("cursor after A", 32'(cursor), 32'h01);
    wait_idle();
    read_chk(0, 8'h41);
    pulse_at(1'b0, 1'b1, 4'hF, 13, cyc + 14);
    send_byte(1'b0, 8'hA8); wait_idle();
    send_byte(1'b1, 8'h42); wait_idle();
    read_chk(16, 8'h42);
    check("cursor after B", 32'(cursor), 32'h29);
    send_byte(1'b0, 8'h90); wait_idle();
    send_byte(1'b1, 8'h43);
    check("wr_strobe unmapped", 32'(wr_strobe), 32'h0);
    wait_idle();
    check("cursor after unmapped", 32'(cursor), 32'h11);
    sweep_model();
    send_byte(1'b0, 8'h04); wait_idle();
    send_byte(1'b0, 8'h85); wait_idle();
    send_byte(1'b1, 8'h44); wait_idle();
    check("cursor decrement", 32'(cursor), 32'h04);
    read_chk(5, 8'h44);
    send_byte(1'b0, 8'h80); wait_idle();
    send_byte(1'b1, 8'h45); wait_idle();
    check("cursor wrap", 32'(cursor), 32'h7F);
    read_chk(0, 8'h45);
    send_byte(1'b0, 8'h06); wait_idle();

    // 5a: pulse while busy
    send_byte(1'b0, 8'h80);
    t0 = cyc;
    pulse_at(1'b1, 1'b0, 4'h5, 13, t0 + 100);
    check("error busy pulse", 32'(error), 32'h1);
    wait_idle();
    sweep_model();
    read_chk(16, 8'h42);

    // 5b: minimum width accepted, one cycle early rejected
    do_reset();
    check("error after reset", 32'(error), 32'h0);
    send(1'b0, 4'h3, MIN_E);
    check("width min accepted", 32'({error, busy}), 32'b01);
    pulse_at(1'b0, 1'b0, 4'h3, 13, m_busy_end - 3);
    check("error early pulse", 32'(error), 32'h1);
    wait_idle();

    // 5c: short pulse
    do_reset();
    send(1'b0, 4'h3, 5);
    check("error short pulse", 32'({error, busy}), 32'b10);

    // 6: reset discards pending upper nibble
    do_reset();
    init_4bit();
    send(1'b0, 4'h4, 13);
    do_reset();
    check("mode_4bit after reset", 32'(mode_4bit), 32'h0);
    send(1'b0, 4'h3, 13);
    check("post-reset 0x3", 32'({error, busy}), 32'b01);
    wait_idle();
    send(1'b0, 4'h2, 13);
    check("post-reset 0x2", 32'({error, mode_4bit}), 32'b01);
    wait_idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_responder.md
# lcd_responder

HD44780-compatible responder for the 4-bit character-LCD bus (SF_D[11:8], LCD_E, LCD_RS, LCD_RW). It sits on the panel side of the LCD controller and receives its bus traffic. It tracks the power-on init handshake, reassembles nibble pairs, executes commands, and holds a 32-character display image. The image can be read back, and the block flags protocol-timing violations. It serves as an on-chip checker or loopback target.

## Interface
- BUSY_CMD, 2000: busy cycles after a normal command or character write.
- BUSY_CLEAR, 82000: busy cycles after clear or return-home.
- MIN_E_HIGH, 12: minimum LCD_E high width, in clk cycles.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- SF_D  in  4  data nibble, bits [11:8].
- LCD_E  in  1  enable strobe.
- LCD_RS  in  1  0 = command, 1 = data.
- LCD_RW  in  1  0 = write; 1 = read (ignored).
- rd_addr  in  5  display-image read index (0–15 = line 1, 16–31 = line 2).
- rd_data  out  8  image byte at rd_addr.
- busy  out  1  execution timer running.
- error  out  1  sticky protocol-violation flag.
- mode_4bit  out  1  4-bit interface established.
- display_on  out  1  display-control D bit.
- cursor  out  7  current DDRAM address.
- wr_strobe  out  1  one-cycle pulse per stored character.
- wr_char  out  8  character written; valid with wr_strobe.

## Operation
- **Input capture.** SF_D, LCD_E, LCD_RS and LCD_RW pass through a 2-flop synchronizer.
- **Pulses.** A pulse is a synced-E rising edge followed by a falling edge. The high width is counted; data and RS are sampled on the falling edge. Pulses with RW=1 are discarded.
- **Pulse violations** set `error` and discard the pulse:
  - high width < MIN_E_HIGH;
  - pulse falls while busy = 1.
- **State S_8BIT** (reset state). Each pulse is one command, with byte = {SF_D, 4'h0}:
  - SF_D = 0x3: stay in S_8BIT, start BUSY_CMD.
  - SF_D = 0x2: go to S_4BIT_HI, set mode_4bit, start BUSY_CMD.
  - any other value: set error, stay.
- **State S_4BIT_HI.** Latch the nibble as the upper half, go to S_4BIT_LO. No busy.
- **State S_4BIT_LO.** Form the byte {hi, SF_D}, execute it, return to S_4BIT_HI.
- **Command decode** (RS=0), priority on the highest set bit:
  - 0x80–0xFF: cursor = byte[6:0]; BUSY_CMD.
  - 0x40–0x7F: CGRAM address, ignored; BUSY_CMD.
  - 0x20–0x3F: function set. If DL (bit4) = 1, go to S_8BIT and clear mode_4bit. BUSY_CMD.
  - 0x10–0x1F: shift, ignored; BUSY_CMD.
  - 0x08–0x0F: display_on = bit2; BUSY_CMD.
  - 0x04–0x07: store I/D = bit1; BUSY_CMD.
  - 0x02–0x03: cursor = 0; BUSY_CLEAR.
  - 0x01: fill the image with 0x20 (32 cycles, hidden under busy), cursor = 0, I/D = 1; BUSY_CLEAR.
  - 0x00: no-op, no busy.
- **Data write** (RS=1):
  - Address map: cursor 0x00–0x0F → index 0–15; cursor 0x28–0x37 → index 16–31.
  - Mapped cursor: store the byte and pulse wr_strobe with wr_char.
  - Unmapped cursor: discard the byte; no strobe.
  - Either way, cursor ±1 per I/D, modulo 128; start BUSY_CMD.
- **Read port.** rd_data is registered; it shows the image at rd_addr one cycle later.

## Timing
- **Reset values:** rd_data = 0x20, busy 0, error 0, mode_4bit 0, display_on 0, cursor 0, wr_strobe 0, wr_char 0. Image is all 0x20, I/D = 1, state S_8BIT, timers 0.
- **Latency:** the effect (state, cursor, image, wr_strobe, busy rise) appears 3 clk after the pin-level LCD_E falling edge.
- **Busy duration:** busy stays high for exactly N cycles (BUSY_CMD or BUSY_CLEAR). A pulse whose falling edge is detected on the cycle busy deasserts is accepted.
- **Reset mid-operation:** rst_n low at any time returns all outputs to their reset values. A pending upper nibble and an in-progress clear fill are discarded.
- **error** clears only on reset.

## Test plan
1. Reset, then sweep rd_addr 0–31 → rd_data = 0x20 everywhere; all flags 0.
2. Nibbles 0x3, 0x3, 0x3, 0x2, each with E high 13 cycles and spaced 2100 cycles → mode_4bit = 1, error = 0.
3. After test 2, send bytes 0x28, 0x06, 0x0C, 0x01 →
   - display_on = 1;
   - busy high 82000 cycles after the final nibble;
   - image all 0x20; cursor = 0.
4. Character writes:
   - 0x80 then RS=1 0x41 → wr_strobe with wr_char = 0x41; rd_addr 0 → 0x41; cursor = 1.
   - 0xA8 then 0x42 → index 16 = 0x42.
   - 0x90 then 0x43 → no strobe; image unchanged.
5. Violations:
   - pulse 100 cycles after a command → error = 1, image unchanged;
   - after reset, E high 5 cycles → error = 1.
6. Send upper nibble 0x4, then pulse rst_n → state S_8BIT, mode_4bit = 0; a following nibble 0x3 is accepted without error.
